// File: rtl/spi_xfer_sched_if.sv
// Requester and engine handshake bundle for spi_xfer_sched.
// slave is the scheduler's view; master is the requester/engine side.
interface spi_xfer_sched_if #(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned DW    = 16
);
  logic [N_REQ-1:0]    req;
  logic [N_REQ*DW-1:0] req_tx;
  logic [N_REQ-1:0]    gnt;
  logic [N_REQ-1:0]    rsp_valid;
  logic [DW-1:0]       rsp_data;
  logic                rsp_err;
  logic                eng_start;
  logic [DW-1:0]       eng_tx;
  logic                eng_abort;
  logic                eng_done;
  logic [DW-1:0]       eng_rx;
  logic                busy;

  modport slave (
    input  req, req_tx, eng_done, eng_rx,
    output gnt, rsp_valid, rsp_data, rsp_err, eng_start, eng_tx, eng_abort, busy
  );

  modport master (
    output req, req_tx, eng_done, eng_rx,
    input  gnt, rsp_valid, rsp_data, rsp_err, eng_start, eng_tx, eng_abort, busy
  );
endinterface

// File: rtl/spi_xfer_sched.sv
// Round-robin scheduler sharing one SPI transfer engine between N_REQ requesters,
// with an enforced cs_n-high gap between frames and a stuck-transfer watchdog.
module spi_xfer_sched #(
  parameter int unsigned N_REQ       = 4,
  parameter int unsigned DW          = 16,
  parameter int unsigned GAP_CYC     = 4,
  parameter int unsigned TIMEOUT_CYC = 64
) (
  input logic              clk,
  input logic              rst_a,
  spi_xfer_sched_if.slave  bus
);
  localparam int unsigned PW = $clog2(N_REQ);
  localparam int unsigned TW = $clog2(TIMEOUT_CYC);
  localparam int unsigned GW = $clog2(GAP_CYC + 1);

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_GAP} state_e;

  state_e           state_q, state_d;
  logic [PW-1:0]    rr_ptr_q, rr_ptr_d;
  logic [PW-1:0]    owner_q, owner_d;
  logic [TW-1:0]    tmo_cnt_q, tmo_cnt_d;
  logic [GW-1:0]    gap_cnt_q, gap_cnt_d;
  logic [N_REQ-1:0] gnt_q, gnt_d;
  logic [N_REQ-1:0] rsp_valid_q, rsp_valid_d;
  logic [DW-1:0]    rsp_data_q, rsp_data_d;
  logic             rsp_err_q, rsp_err_d;
  logic             eng_start_q, eng_start_d;
  logic [DW-1:0]    eng_tx_q, eng_tx_d;
  logic             eng_abort_q, eng_abort_d;
  logic             busy_q, busy_d;

  logic             pick_vld;
  logic [PW-1:0]    pick_idx;
  logic [DW-1:0]    pick_tx;
  logic [PW:0]      cand;

  // First requesting index at or after rr_ptr, wrapping modulo N_REQ
  always_comb begin
    pick_vld = 1'b0;
    pick_idx = '0;
    cand     = '0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      cand = {1'b0, rr_ptr_q} + (PW + 1)'(k);
      if (cand >= (PW + 1)'(N_REQ)) begin
        cand = cand - (PW + 1)'(N_REQ);
      end
      if (!pick_vld && bus.req[cand[PW-1:0]]) begin
        pick_vld = 1'b1;
        pick_idx = cand[PW-1:0];
      end
    end
  end

  always_comb begin
    pick_tx = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (pick_idx == PW'(i)) begin
        pick_tx = bus.req_tx[i*DW +: DW];
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    owner_d     = owner_q;
    tmo_cnt_d   = tmo_cnt_q;
    gap_cnt_d   = gap_cnt_q;
    gnt_d       = '0;
    rsp_valid_d = '0;
    rsp_data_d  = rsp_data_q;
    rsp_err_d   = rsp_err_q;
    eng_start_d = 1'b0;
    eng_tx_d    = eng_tx_q;
    eng_abort_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (pick_vld) begin
          state_d     = ST_WAIT;
          gnt_d       = N_REQ'(1) << pick_idx;
          eng_start_d = 1'b1;
          eng_tx_d    = pick_tx;
          owner_d     = pick_idx;
          rr_ptr_d    = (pick_idx == PW'(N_REQ - 1)) ? '0 : PW'(pick_idx + PW'(1));
          tmo_cnt_d   = '0;
        end
      end
      ST_WAIT: begin
        tmo_cnt_d = tmo_cnt_q + TW'(1);
        // A done arriving on the last watchdog cycle still counts as success
        if (bus.eng_done) begin
          state_d     = ST_GAP;
          gap_cnt_d   = '0;
          rsp_valid_d = N_REQ'(1) << owner_q;
          rsp_data_d  = bus.eng_rx;
          rsp_err_d   = 1'b0;
        end else if (tmo_cnt_q == TW'(TIMEOUT_CYC - 1)) begin
          state_d     = ST_GAP;
          gap_cnt_d   = '0;
          eng_abort_d = 1'b1;
          rsp_valid_d = N_REQ'(1) << owner_q;
          rsp_data_d  = '0;
          rsp_err_d   = 1'b1;
        end
      end
      ST_GAP: begin
        if (gap_cnt_q == GW'(GAP_CYC - 1)) begin
          state_d = ST_IDLE;
        end else begin
          gap_cnt_d = gap_cnt_q + GW'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or posedge rst_a) begin
    if (rst_a) begin
      state_q     <= ST_IDLE;
      rr_ptr_q    <= '0;
      owner_q     <= '0;
      tmo_cnt_q   <= '0;
      gap_cnt_q   <= '0;
      gnt_q       <= '0;
      rsp_valid_q <= '0;
      rsp_data_q  <= '0;
      rsp_err_q   <= 1'b0;
      eng_start_q <= 1'b0;
      eng_tx_q    <= '0;
      eng_abort_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      owner_q     <= owner_d;
      tmo_cnt_q   <= tmo_cnt_d;
      gap_cnt_q   <= gap_cnt_d;
      gnt_q       <= gnt_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_err_q   <= rsp_err_d;
      eng_start_q <= eng_start_d;
      eng_tx_q    <= eng_tx_d;
      eng_abort_q <= eng_abort_d;
      busy_q      <= busy_d;
    end
  end

  assign bus.gnt       = gnt_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_data  = rsp_data_q;
  assign bus.rsp_err   = rsp_err_q;
  assign bus.eng_start = eng_start_q;
  assign bus.eng_tx    = eng_tx_q;
  assign bus.eng_abort = eng_abort_q;
  assign bus.busy      = busy_q;
endmodule

// File: tb/tb_spi_xfer_sched.sv
// Directed bench for spi_xfer_sched: expected responses are queued when a frame
// is finished or left to time out, and popped whenever rsp_valid appears.
module tb_spi_xfer_sched;
  localparam int unsigned N  = 4;
  localparam int unsigned DW = 16;
  localparam int unsigned G  = 4;
  localparam int unsigned T  = 64;

  typedef struct {
    int            idx;
    logic [DW-1:0] data;
    logic          err;
  } exp_t;

  logic clk;
  logic rst_a;

  spi_xfer_sched_if #(.N_REQ(N), .DW(DW)) bus ();

  spi_xfer_sched #(.N_REQ(N), .DW(DW), .GAP_CYC(G), .TIMEOUT_CYC(T)) dut (
    .clk   (clk),
    .rst_a (rst_a),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  exp_t        sb[$];
  int          vectors = 0;
  int          miscompares = 0;
  int          cyc = 0;
  int          start_cyc = -1;
  int          abort_cyc = -1;
  int          rsp_cyc = -1;
  int          done_cyc = -1;
  logic [N-1:0] gnt_acc = '0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock step; every response the DUT produces is scored here
  task automatic tick();
    exp_t e;
    @(posedge clk);
    #1;
    cyc++;
    gnt_acc |= bus.gnt;
    if (bus.eng_start === 1'b1) start_cyc = cyc;
    if (bus.eng_abort === 1'b1) abort_cyc = cyc;
    if (bus.rsp_valid !== '0) begin
      rsp_cyc = cyc;
      if (sb.size() == 0) begin
        check("stray_rsp", 32'(bus.rsp_valid), 32'(0));
      end else begin
        e = sb.pop_front();
        check("rsp_valid", 32'(bus.rsp_valid), 32'(1) << e.idx);
        check("rsp_data", 32'(bus.rsp_data), 32'(e.data));
        check("rsp_err", 32'(bus.rsp_err), 32'(e.err));
        check("abort_vs_err", 32'(bus.eng_abort), 32'(e.err));
      end
    end else if (bus.eng_abort !== 1'b0) begin
      check("lone_abort", 32'(bus.eng_abort), 32'(0));
    end
  endtask

  task automatic wait_gnt(input int budget, output logic [N-1:0] g);
    g = '0;
    for (int i = 0; i < budget; i++) begin
      tick();
      if (bus.gnt !== '0) begin
        g = bus.gnt;
        break;
      end
    end
    check("gnt_within_budget", 32'(g != '0), 32'(1));
  endtask

  task automatic wait_abort(input int budget);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < budget; i++) begin
      tick();
      if (bus.eng_abort === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
    check("abort_within_budget", 32'(seen), 32'(1));
  endtask

  task automatic finish_done(input int idx, input logic [DW-1:0] rx);
    exp_t e;
    e.idx  = idx;
    e.data = rx;
    e.err  = 1'b0;
    sb.push_back(e);
    bus.eng_rx   = rx;
    bus.eng_done = 1'b1;
    done_cyc     = cyc;
    tick();
    bus.eng_done = 1'b0;
    check("done_to_rsp", 32'(rsp_cyc - done_cyc), 32'(1));
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_ctl"}, 32'({bus.gnt, bus.rsp_valid, bus.rsp_err, bus.eng_start,
                              bus.eng_abort, bus.busy}), 32'(0));
    check({tag, "_rsp_data"}, 32'(bus.rsp_data), 32'(0));
    check({tag, "_eng_tx"}, 32'(bus.eng_tx), 32'(0));
  endtask

  initial begin
    logic [N-1:0] g;
    int           t_start;
    int           rr_exp[5];
    exp_t         e;
    rr_exp = '{0, 1, 2, 3, 0};

    rst_a        = 1'b1;
    bus.req      = '0;
    bus.req_tx   = '0;
    bus.eng_done = 1'b0;
    bus.eng_rx   = '0;
    tick();
    tick();
    check_zero("reset");
    rst_a = 1'b0;
    tick();

    // Single request from requester 2
    bus.req_tx[2*DW +: DW] = 16'hA5C3;
    bus.req = 4'b0100;
    tick();
    check("t1_gnt", 32'(bus.gnt), 32'(4'b0100));
    check("t1_start", 32'(bus.eng_start), 32'(1));
    check("t1_tx", 32'(bus.eng_tx), 32'(16'hA5C3));
    check("t1_busy", 32'(bus.busy), 32'(1));
    bus.req = '0;
    t_start = start_cyc;
    repeat (33) tick();
    check("t1_tx_stable", 32'(bus.eng_tx), 32'(16'hA5C3));
    finish_done(2, 16'h1234);
    check("t1_rsp_cycle", 32'(rsp_cyc - t_start), 32'(34));
    tick();
    check("t1_data_hold", 32'(bus.rsp_data), 32'(16'h1234));

    // Request pulsed during GAP is withdrawn; stray done in IDLE is ignored
    gnt_acc = '0;
    bus.req = 4'b1000;
    tick();
    bus.req = '0;
    repeat (10) tick();
    check("gap_pulse_not_granted", 32'(gnt_acc), 32'(0));
    check("idle_busy", 32'(bus.busy), 32'(0));
    bus.eng_rx   = 16'hFFFF;
    bus.eng_done = 1'b1;
    tick();
    bus.eng_done = 1'b0;
    check("stray_done_no_rsp", 32'(bus.rsp_valid), 32'(0));
    repeat (3) tick();

    // Timeout: rr_ptr is 3, so requester 0 wins over 1
    bus.req_tx[0*DW +: DW] = 16'h1111;
    bus.req_tx[1*DW +: DW] = 16'h2222;
    bus.req = 4'b0011;
    wait_gnt(4, g);
    check("t3_gnt", 32'(g), 32'(4'b0001));
    bus.req = 4'b0010;
    t_start = start_cyc;
    e.idx = 0; e.data = '0; e.err = 1'b1;
    sb.push_back(e);
    wait_abort(T + 10);
    check("t3_abort_latency", 32'(abort_cyc - t_start), 32'(T));
    wait_gnt(G + 6, g);
    check("t3_next_gnt", 32'(g), 32'(4'b0010));
    check("t3_gap", 32'(start_cyc - abort_cyc), 32'(G + 1));
    check("t3_next_tx", 32'(bus.eng_tx), 32'(16'h2222));
    bus.req = '0;

    // Done lands on the last watchdog cycle: normal response wins
    t_start = start_cyc;
    repeat (T - 1) tick();
    finish_done(1, 16'hBEEF);
    check("t4_rsp_cycle", 32'(rsp_cyc - t_start), 32'(T));
    check("t4_no_abort", 32'(bus.eng_abort), 32'(0));
    repeat (G + 2) tick();

    // Reset in the middle of WAIT: requester 2 in flight, rr_ptr must return to 0
    bus.req_tx[2*DW +: DW] = 16'h7777;
    bus.req = 4'b0100;
    wait_gnt(4, g);
    check("t5_gnt", 32'(g), 32'(4'b0100));
    bus.req = '0;
    repeat (10) tick();
    #2;
    rst_a = 1'b1;
    #1;
    check_zero("t5_async");
    tick();
    rst_a = 1'b0;
    repeat (3) tick();
    bus.req_tx[1*DW +: DW] = 16'h3333;
    bus.req_tx[3*DW +: DW] = 16'h4444;
    bus.req = 4'b1010;
    wait_gnt(4, g);
    check("t5_ptr_reset", 32'(g), 32'(4'b0010));
    check("t5_tx", 32'(bus.eng_tx), 32'(16'h3333));
    bus.req = '0;
    repeat (20) tick();
    finish_done(1, 16'h5A5A);
    repeat (G + 2) tick();

    // Round-robin with all four requesting, each re-asserting after its grant
    rst_a = 1'b1;
    tick();
    rst_a = 1'b0;
    tick();
    for (int i = 0; i < N; i++) bus.req_tx[i*DW +: DW] = 16'hC000 + 16'(i);
    bus.req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      wait_gnt(G + 10, g);
      check("rr_gnt", 32'(g), 32'(1) << rr_exp[k]);
      check("rr_tx", 32'(bus.eng_tx), 32'(16'hC000 + 16'(rr_exp[k])));
      if (k > 0) check("rr_spacing", 32'(start_cyc - done_cyc), 32'(G + 2));
      bus.req[rr_exp[k]] = 1'b0;
      repeat (5) tick();
      bus.req[rr_exp[k]] = 1'b1;
      repeat (14) tick();
      finish_done(rr_exp[k], 16'h1000 + 16'(k));
    end
    bus.req = '0;
    repeat (G + 3) tick();

    check("scoreboard_empty", 32'(sb.size()), 32'(0));
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/spi_xfer_sched.md
Name: spi_xfer_sched

Overview:
- Schedules and arbitrates one shared SPI transfer engine (sclk_n/cs_n/from_device generator) between N_REQ requesters.
- Round-robin grants; one 16-bit word per transfer; enforces minimum cs_n-high gap between frames and a watchdog on stuck transfers.
- Sits between protocol clients (ADC poll, config writer) and the SPI engine; all outputs registered, glitch-free.

Parameters:
- N_REQ, 4, number of requesters (2..8)
- DW, 16, transfer word width (bits per cs_n frame)
- GAP_CYC, 4, clk cycles idle between eng_done and next eng_start (>=1)
- TIMEOUT_CYC, 64, max cycles in WAIT before abort (> DW*2+2)

Ports:
- clk  in  1  system clock
- rst_a  in  1  asynchronous reset, active-high
- req  in  N_REQ  per-requester transfer request, level, held until gnt
- req_tx  in  N_REQ*DW  per-requester tx word, slice i = req_tx[i*DW +: DW]
- gnt  out  N_REQ  one-hot, one-cycle pulse: request accepted, tx captured
- rsp_valid  out  N_REQ  one-hot, one-cycle pulse: rsp_data/rsp_err valid for requester i
- rsp_data  out  DW  received word (0 on error)
- rsp_err  out  1  qualifies rsp_valid: 1 = transfer aborted by timeout
- eng_start  out  1  one-cycle pulse to engine: begin frame
- eng_tx  out  DW  word to shift out, stable from eng_start to eng_done
- eng_abort  out  1  one-cycle pulse: engine forces cs_n high, returns idle
- eng_done  in  1  engine one-cycle pulse: frame complete, eng_rx valid
- eng_rx  in  DW  received word from from_device shift register
- busy  out  1  high in any state except IDLE

Behaviour:
- Reset (rst_a high, async): state=IDLE, rr_ptr=0, gnt=0, rsp_valid=0, rsp_data=0, rsp_err=0, eng_start=0, eng_tx=0, eng_abort=0, busy=0, counters=0. Reset mid-transfer drops everything; no rsp issued for in-flight request; engine is reset by same rst_a.
- FSM states: IDLE, WAIT, GAP.
- IDLE: if any req bit set at edge t, pick first set bit searching rr_ptr, rr_ptr+1, ... modulo N_REQ. At t+1: gnt[i]=1, eng_start=1, eng_tx=req_tx slice i, owner=i, rr_ptr=(i+1) mod N_REQ, state=WAIT, tmo_cnt=0.
- WAIT: tmo_cnt increments each cycle. On eng_done: next cycle rsp_valid[owner]=1, rsp_data=eng_rx, rsp_err=0, state=GAP, gap_cnt=0. If tmo_cnt reaches TIMEOUT_CYC-1 without eng_done: next cycle eng_abort=1, rsp_valid[owner]=1, rsp_err=1, rsp_data=0, state=GAP.
- eng_done and timeout in same cycle: done wins (normal response).
- eng_done outside WAIT: ignored, no response.
- GAP: stays exactly GAP_CYC cycles, then IDLE. Arbitration restarts in IDLE, so minimum eng_done-to-next-eng_start = GAP_CYC+2 cycles.
- Requests seen during WAIT/GAP are not granted until IDLE; req deasserted before gnt is withdrawn silently.
- Requester must drop req in the cycle after gnt or it is treated as a new request (eligible after its round-robin turn).
- Latency: req->gnt/eng_start = 1 cycle from IDLE; eng_done->rsp_valid = 1 cycle.
- gnt, rsp_valid, eng_start, eng_abort: each 1 cycle max, all registered. rsp_data/rsp_err hold last value until next response.
- Counters: tmo_cnt width clog2(TIMEOUT_CYC), gap_cnt width clog2(GAP_CYC+1); no wrap in normal use.

Test Plan:
- Single request: req[2]=1, req_tx[2]=16'hA5C3, engine model returns eng_rx=16'h1234 after 34 cycles -> gnt[2] and eng_start 1 cycle after req, eng_tx=16'hA5C3; rsp_valid[2], rsp_data=16'h1234, rsp_err=0 one cycle after eng_done.
- Round-robin: req=4'b1111 held, re-asserted after each gnt -> grant order 0,1,2,3,0; each eng_start spaced >= GAP_CYC+2 cycles after previous eng_done.
- Timeout: engine never asserts eng_done -> eng_abort, rsp_valid[owner], rsp_err=1, rsp_data=0 exactly TIMEOUT_CYC cycles after eng_start; next grant after GAP.
- Done/timeout collision: eng_done on cycle TIMEOUT_CYC-1 of WAIT -> rsp_err=0, rsp_data=eng_rx, no eng_abort.
- Reset mid-WAIT: assert rst_a during frame -> all outputs 0 asynchronously, state IDLE, rr_ptr=0; after release req[1]=1 granted normally, no stale rsp_valid.
- Withdrawn/late requests: req[3] pulsed 1 cycle during GAP then dropped -> never granted; stray eng_done in IDLE -> no rsp_valid.
